// File: rtl/mpu_regmap_pkg.sv
// MPU-6050 register map constants and I2C target state encoding, shared with the MPU controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mpu_regmap_pkg;

   localparam logic [7:0] PWR_MGMT_1   = 8'h6B;
   localparam logic [7:0] SMPLRT_DIV   = 8'h19;
   localparam logic [7:0] GYRO_CONFIG  = 8'h1B;
   localparam logic [7:0] ACCEL_CONFIG = 8'h1C;
   localparam logic [7:0] ACCEL_XOUT_H = 8'h3B;
   localparam logic [7:0] GYRO_XOUT_H  = 8'h43;
   localparam logic [7:0] WHO_AM_I     = 8'h75;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_REG_ADDR,
      ST_REG_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_LOAD,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } tgt_state_t;

   // Power-on contents of one register: the sensor wakes up asleep and reports its identity.
   function automatic logic [7:0] reg_reset_val(input logic [6:0] addr, input logic [7:0] who_am_i);
      logic [7:0] v;
      v = 8'h00;
      if (addr == PWR_MGMT_1[6:0]) v = 8'h40;
      if (addr == WHO_AM_I[6:0])   v = who_am_i;
      return v;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the clock domain and flags SCL edges plus START/STOP conditions.
// Latency: 2 clocks of synchronizer, detect flags valid the following clock (edge-history stage).
// Backpressure: none; flags are single-cycle pulses that must be consumed when asserted.
module i2c_line_sync (
   input  logic clock,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   // [0],[1] form the synchronizer, [2] holds the previous synchronized value for edge detection.
   logic [2:0] scl_q;
   logic [2:0] sda_q;

   // Shift both lines through the sync chain; an idle bus is high, so reset to ones.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], scl};
         sda_q <= {sda_q[1:0], sda};
      end
   end

   assign sda_s     = sda_q[1];
   assign scl_rise  =  scl_q[1] & ~scl_q[2];
   assign scl_fall  = ~scl_q[1] &  scl_q[2];
   // SCL must be high on both samples so a simultaneous SCL/SDA fall is not taken as START.
   assign start_det = scl_q[1] & scl_q[2] &  sda_q[2] & ~sda_q[1];
   assign stop_det  = scl_q[1] & scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/mpu_i2c_target.sv
// I2C target emulating the MPU-6050 register file, with a local port for loading sensor bytes.
// Latency: en_sda/bus_wr update 3 clocks after the SCL pin edge; loc_rdata is combinational.
// Backpressure: none; SCL is never stretched, local writes always accepted (local beats bus).
module mpu_i2c_target
   import mpu_regmap_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR     = 7'h68,
   parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       scl,
   inout  tri         sda,
   output logic       en_sda,
   input  logic       loc_we,
   input  logic [6:0] loc_addr,
   input  logic [7:0] loc_wdata,
   output logic [7:0] loc_rdata,
   output logic       bus_wr,
   output logic [6:0] bus_wr_addr,
   output logic       busy
);

   logic scl_rise, scl_fall, sda_s, start_det, stop_det;

   tgt_state_t state, state_n;
   logic [2:0] cnt, cnt_n;
   logic       rdy, rdy_n;        // 8 bits received/sent, waiting for the SCL fall that ends the byte
   logic [7:0] shift, shift_n;
   logic [6:0] ptr, ptr_n;
   logic       rw, rw_n;
   logic       en_n, busy_n, wr_n;
   logic [6:0] wr_addr_n;
   logic       bus_we;
   logic [7:0] regs [128];
   logic [7:0] rd_byte;

   assign sda       = en_sda ? 1'b0 : 1'bz;
   assign loc_rdata = regs[loc_addr];
   assign rd_byte   = regs[ptr];

   i2c_line_sync u_sync (
      .clock     (clock),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   // Register the protocol state and every bus-facing output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= 3'd0;
         rdy         <= 1'b0;
         shift       <= 8'h00;
         ptr         <= 7'd0;
         rw          <= 1'b0;
         en_sda      <= 1'b0;
         busy        <= 1'b0;
         bus_wr      <= 1'b0;
         bus_wr_addr <= 7'd0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         rdy         <= rdy_n;
         shift       <= shift_n;
         ptr         <= ptr_n;
         rw          <= rw_n;
         en_sda      <= en_n;
         busy        <= busy_n;
         bus_wr      <= wr_n;
         bus_wr_addr <= wr_addr_n;
      end
   end

   // Next-state logic: bits shift in on SCL rise, SDA drive and byte decisions happen on SCL fall.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      rdy_n     = rdy;
      shift_n   = shift;
      ptr_n     = ptr;
      rw_n      = rw;
      en_n      = en_sda;
      busy_n    = busy;
      wr_n      = 1'b0;
      wr_addr_n = bus_wr_addr;
      bus_we    = 1'b0;
      if (stop_det) begin
         state_n = ST_IDLE;
         en_n    = 1'b0;
         busy_n  = 1'b0;
      end else if (start_det) begin
         state_n = ST_DEV_ADDR;
         cnt_n   = 3'd0;
         rdy_n   = 1'b0;
         en_n    = 1'b0;
      end else if (scl_rise) begin
         case (state)
            ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
               shift_n = {shift[6:0], sda_s};
               cnt_n   = cnt + 3'd1;
               rdy_n   = (cnt == 3'd7);
            end
            ST_RD_DATA: begin
               cnt_n = cnt + 3'd1;
               rdy_n = (cnt == 3'd7);
            end
            ST_DEV_ACK: if (rw) state_n = ST_RD_LOAD;
            ST_RD_ACK:  state_n = sda_s ? ST_IGNORE : ST_RD_LOAD;
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state)
            ST_DEV_ADDR: if (rdy) begin
               rdy_n = 1'b0;
               if (shift[7:1] == DEV_ADDR) begin
                  en_n    = 1'b1;
                  busy_n  = 1'b1;
                  rw_n    = shift[0];
                  state_n = ST_DEV_ACK;
               end else begin
                  busy_n  = 1'b0;
                  state_n = ST_IGNORE;
               end
            end
            ST_DEV_ACK: begin
               en_n    = 1'b0;
               state_n = ST_REG_ADDR;
            end
            ST_REG_ADDR: if (rdy) begin
               rdy_n   = 1'b0;
               ptr_n   = shift[6:0];
               en_n    = 1'b1;
               state_n = ST_REG_ACK;
            end
            ST_REG_ACK, ST_WR_ACK: begin
               en_n    = 1'b0;
               state_n = ST_WR_DATA;
            end
            ST_WR_DATA: if (rdy) begin
               rdy_n     = 1'b0;
               bus_we    = 1'b1;
               wr_n      = 1'b1;
               wr_addr_n = ptr;
               ptr_n     = ptr + 7'd1;
               en_n      = 1'b1;
               state_n   = ST_WR_ACK;
            end
            ST_RD_LOAD: begin
               shift_n = rd_byte;
               en_n    = ~rd_byte[7];
               ptr_n   = ptr + 7'd1;
               cnt_n   = 3'd0;
               rdy_n   = 1'b0;
               state_n = ST_RD_DATA;
            end
            ST_RD_DATA: begin
               if (rdy) begin
                  rdy_n   = 1'b0;
                  en_n    = 1'b0;
                  state_n = ST_RD_ACK;
               end else begin
                  shift_n = {shift[6:0], 1'b0};
                  en_n    = ~shift[6];
               end
            end
            default: ;
         endcase
      end
   end

   // Register file; the local write is applied last so it wins a same-cycle collision.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) regs[i] <= reg_reset_val(7'(i), WHO_AM_I_VAL);
      end else begin
         if (bus_we) regs[ptr] <= shift;
         if (loc_we) regs[loc_addr] <= loc_wdata;
      end
   end

endmodule

// File: tb/tb_mpu_i2c_target.sv
// Directed bench for mpu_i2c_target: acts as the I2C initiator and local-port stimulus source.
// Latency: n/a.
// Backpressure: n/a.
module tb_mpu_i2c_target;
   import mpu_regmap_pkg::*;

   localparam int TQ = 8;   // quarter SCL period in clocks (SCL = clock/32)

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       tb_sda = 1'b1;
   logic       loc_we = 1'b0;
   logic [6:0] loc_addr = 7'd0;
   logic [7:0] loc_wdata = 8'd0;
   logic [7:0] loc_rdata;
   logic       en_sda, bus_wr, busy;
   logic [6:0] bus_wr_addr;
   tri         sda;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_pulses = 0;
   int en_cnt = 0;

   // Open-drain bus: the bench drives only while the target is not pulling low.
   assign sda = en_sda ? 1'bz : tb_sda;

   mpu_i2c_target #(.DEV_ADDR(7'h68), .WHO_AM_I_VAL(8'h68)) dut (
      .clock       (clock),
      .reset       (reset),
      .scl         (scl),
      .sda         (sda),
      .en_sda      (en_sda),
      .loc_we      (loc_we),
      .loc_addr    (loc_addr),
      .loc_wdata   (loc_wdata),
      .loc_rdata   (loc_rdata),
      .bus_wr      (bus_wr),
      .bus_wr_addr (bus_wr_addr),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // Count bus_wr high cycles and cycles with the target driving SDA.
   always @(negedge clock) begin
      if (bus_wr) wr_pulses++;
      if (en_sda) en_cnt++;
   end

   task automatic wait_q(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic peek(input logic [6:0] a, output logic [7:0] d);
      loc_addr = a;
      #1;
      d = loc_rdata;
   endtask

   task automatic loc_write(input logic [6:0] a, input logic [7:0] d);
      loc_addr = a; loc_wdata = d; loc_we = 1'b1;
      wait_q(1);
      loc_we = 1'b0;
   endtask

   task automatic i2c_start;
      tb_sda = 1'b1; wait_q(TQ); scl = 1'b1; wait_q(TQ);
      tb_sda = 1'b0; wait_q(TQ); scl = 1'b0; wait_q(TQ);
   endtask

   task automatic i2c_stop;
      tb_sda = 1'b0; wait_q(TQ); scl = 1'b1; wait_q(TQ); tb_sda = 1'b1; wait_q(TQ);
   endtask

   // inject: raise loc_we in exactly the cycle the target commits the byte (3rd clock after SCL fall).
   task automatic write_byte(input logic [7:0] b, input bit inject, output logic ack, output logic wr_seen);
      wr_seen = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         tb_sda = b[i]; wait_q(TQ); scl = 1'b1; wait_q(2*TQ); scl = 1'b0;
         if (i == 0 && inject) begin
            wait_q(2); loc_we = 1'b1; wait_q(1); loc_we = 1'b0; wr_seen = bus_wr; wait_q(TQ-3);
         end else begin
            wait_q(TQ);
         end
      end
      tb_sda = 1'b1; wait_q(TQ); scl = 1'b1; wait_q(TQ); ack = ~sda; wait_q(TQ); scl = 1'b0; wait_q(TQ);
   endtask

   task automatic read_byte(input logic ack_bit, output logic [7:0] b);
      b = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         tb_sda = 1'b1; wait_q(TQ); scl = 1'b1; wait_q(TQ); b[i] = sda; wait_q(TQ); scl = 1'b0; wait_q(TQ);
      end
      tb_sda = ack_bit; wait_q(TQ); scl = 1'b1; wait_q(2*TQ); scl = 1'b0; wait_q(TQ);
   endtask

   task automatic test_reset;
      logic [7:0] d;
      wait_q(3);
      reset = 1'b0;
      wait_q(2);
      n_cmp++; if (en_sda !== 1'b0) begin n_bad++; $display("FAIL rst_en_sda: got %b want 0", en_sda); end
      n_cmp++; if (bus_wr !== 1'b0) begin n_bad++; $display("FAIL rst_bus_wr: got %b want 0", bus_wr); end
      n_cmp++; if (bus_wr_addr !== 7'h00) begin n_bad++; $display("FAIL rst_bus_wr_addr: got %h want 00", bus_wr_addr); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      peek(7'h6B, d);
      n_cmp++; if (d !== 8'h40) begin n_bad++; $display("FAIL rst_pwr_mgmt: got %h want 40", d); end
      peek(7'h75, d);
      n_cmp++; if (d !== 8'h68) begin n_bad++; $display("FAIL rst_who_am_i: got %h want 68", d); end
      peek(7'h3B, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_accel: got %h want 00", d); end
   endtask

   task automatic test_write_pwr;
      logic a0, a1, a2, w;
      logic [7:0] d;
      int p0;
      p0 = wr_pulses;
      i2c_start;
      write_byte(8'hD0, 1'b0, a0, w);
      write_byte(8'h6B, 1'b0, a1, w);
      write_byte(8'h00, 1'b0, a2, w);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
      i2c_stop;
      wait_q(4);
      n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL wr_acks: got %b want 111", {a0, a1, a2}); end
      n_cmp++; if (wr_pulses - p0 != 1) begin n_bad++; $display("FAIL wr_pulse_cnt: got %0d want 1", wr_pulses - p0); end
      n_cmp++; if (bus_wr_addr !== 7'h6B) begin n_bad++; $display("FAIL wr_addr: got %h want 6b", bus_wr_addr); end
      peek(7'h6B, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL wr_pwr_mgmt: got %h want 00", d); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_read_burst;
      logic a0, a1, a2, w;
      logic [7:0] d, r0, r1;
      loc_write(7'h3B, 8'h12);
      peek(7'h3B, d);
      n_cmp++; if (d !== 8'h12) begin n_bad++; $display("FAIL rd_loc_visible: got %h want 12", d); end
      loc_write(7'h3C, 8'h34);
      i2c_start;
      write_byte(8'hD0, 1'b0, a0, w);
      write_byte(8'h3B, 1'b0, a1, w);
      i2c_start;
      write_byte(8'hD1, 1'b0, a2, w);
      read_byte(1'b0, r0);
      read_byte(1'b1, r1);
      n_cmp++; if ({a0, a1, a2} !== 3'b111) begin n_bad++; $display("FAIL rd_acks: got %b want 111", {a0, a1, a2}); end
      n_cmp++; if (r0 !== 8'h12) begin n_bad++; $display("FAIL rd_byte0: got %h want 12", r0); end
      n_cmp++; if (r1 !== 8'h34) begin n_bad++; $display("FAIL rd_byte1: got %h want 34", r1); end
      n_cmp++; if (dut.state !== ST_IGNORE) begin n_bad++; $display("FAIL rd_state_nack: got %0d want %0d", dut.state, ST_IGNORE); end
      i2c_stop;
      wait_q(4);
      n_cmp++; if (dut.state !== ST_IDLE) begin n_bad++; $display("FAIL rd_state_stop: got %0d want %0d", dut.state, ST_IDLE); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_wrong_addr;
      logic a0, a1, a2, w;
      logic [7:0] d;
      int p0, e0;
      p0 = wr_pulses;
      e0 = en_cnt;
      i2c_start;
      write_byte(8'hD2, 1'b0, a0, w);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL na_busy: got %b want 0", busy); end
      write_byte(8'h6B, 1'b0, a1, w);
      write_byte(8'h55, 1'b0, a2, w);
      i2c_stop;
      wait_q(4);
      n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL na_acks: got %b want 000", {a0, a1, a2}); end
      n_cmp++; if (en_cnt != e0) begin n_bad++; $display("FAIL na_en_sda_cycles: got %0d want 0", en_cnt - e0); end
      n_cmp++; if (wr_pulses != p0) begin n_bad++; $display("FAIL na_bus_wr: got %0d want 0", wr_pulses - p0); end
      peek(7'h6B, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL na_reg_unchanged: got %h want 00", d); end
   endtask

   task automatic test_wrap;
      logic a0, a1, a2, a3, w;
      logic [7:0] d;
      int p0;
      p0 = wr_pulses;
      i2c_start;
      write_byte(8'hD0, 1'b0, a0, w);
      write_byte(8'h7F, 1'b0, a1, w);
      write_byte(8'hAA, 1'b0, a2, w);
      write_byte(8'hBB, 1'b0, a3, w);
      i2c_stop;
      wait_q(4);
      n_cmp++; if ({a0, a1, a2, a3} !== 4'b1111) begin n_bad++; $display("FAIL wrap_acks: got %b want 1111", {a0, a1, a2, a3}); end
      peek(7'h7F, d);
      n_cmp++; if (d !== 8'hAA) begin n_bad++; $display("FAIL wrap_reg7f: got %h want aa", d); end
      peek(7'h00, d);
      n_cmp++; if (d !== 8'hBB) begin n_bad++; $display("FAIL wrap_reg00: got %h want bb", d); end
      n_cmp++; if (wr_pulses - p0 != 2) begin n_bad++; $display("FAIL wrap_pulse_cnt: got %0d want 2", wr_pulses - p0); end
      n_cmp++; if (bus_wr_addr !== 7'h00) begin n_bad++; $display("FAIL wrap_last_addr: got %h want 00", bus_wr_addr); end
   endtask

   task automatic test_same_cycle;
      logic a0, a1, a2, w;
      logic [7:0] d;
      int p0;
      p0 = wr_pulses;
      loc_addr = 7'h1B;
      loc_wdata = 8'h18;
      i2c_start;
      write_byte(8'hD0, 1'b0, a0, w);
      write_byte(8'h1B, 1'b0, a1, w);
      write_byte(8'h08, 1'b1, a2, w);
      i2c_stop;
      wait_q(4);
      n_cmp++; if (w !== 1'b1) begin n_bad++; $display("FAIL col_bus_wr_same_cycle: got %b want 1", w); end
      n_cmp++; if (a2 !== 1'b1) begin n_bad++; $display("FAIL col_ack: got %b want 1", a2); end
      peek(7'h1B, d);
      n_cmp++; if (d !== 8'h18) begin n_bad++; $display("FAIL col_local_wins: got %h want 18", d); end
      n_cmp++; if (bus_wr_addr !== 7'h1B) begin n_bad++; $display("FAIL col_addr: got %h want 1b", bus_wr_addr); end
      n_cmp++; if (wr_pulses - p0 != 1) begin n_bad++; $display("FAIL col_pulse_cnt: got %0d want 1", wr_pulses - p0); end
   endtask

   task automatic test_reset_mid;
      logic a0, a1, w;
      logic [7:0] d;
      i2c_start;
      write_byte(8'hD0, 1'b0, a0, w);
      write_byte(8'h01, 1'b0, a1, w);
      i2c_stop;
      i2c_start;
      write_byte(8'hD1, 1'b0, a0, w);
      // regs[0x01] is zero, so the target holds SDA low for every data bit
      for (int i = 0; i < 4; i++) begin
         tb_sda = 1'b1; wait_q(TQ); scl = 1'b1; wait_q(2*TQ); scl = 1'b0; wait_q(TQ);
      end
      tb_sda = 1'b1; wait_q(TQ); scl = 1'b1; wait_q(TQ);
      n_cmp++; if (en_sda !== 1'b1) begin n_bad++; $display("FAIL mid_en_before: got %b want 1", en_sda); end
      reset = 1'b1;
      #1;
      n_cmp++; if (en_sda !== 1'b0) begin n_bad++; $display("FAIL mid_en_reset: got %b want 0", en_sda); end
      wait_q(2); scl = 1'b0; wait_q(2); reset = 1'b0; wait_q(2);
      peek(7'h75, d);
      n_cmp++; if (d !== 8'h68) begin n_bad++; $display("FAIL mid_who_am_i: got %h want 68", d); end
      peek(7'h00, d);
      n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL mid_reg00: got %h want 00", d); end
      n_cmp++; if (dut.ptr !== 7'd0) begin n_bad++; $display("FAIL mid_ptr: got %h want 00", dut.ptr); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      loc_write(7'h00, 8'hC3);
      loc_write(7'h02, 8'h5A);
      wait_q(TQ);
      i2c_start;
      write_byte(8'hD1, 1'b0, a0, w);
      read_byte(1'b1, d);
      i2c_stop;
      n_cmp++; if (d !== 8'hC3) begin n_bad++; $display("FAIL mid_cur_read: got %h want c3", d); end
      i2c_start;
      write_byte(8'hD0, 1'b0, a0, w);
      write_byte(8'h75, 1'b0, a1, w);
      i2c_start;
      write_byte(8'hD1, 1'b0, a0, w);
      read_byte(1'b1, d);
      i2c_stop;
      n_cmp++; if (d !== 8'h68) begin n_bad++; $display("FAIL mid_read_who: got %h want 68", d); end
   endtask

   initial begin
      test_reset;
      test_write_pwr;
      test_read_burst;
      test_wrong_addr;
      test_wrap;
      test_same_cycle;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
